// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the serial system bus bridge slave
package bus_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, WAIT, RDATA} bb_state_t;
    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/bus_bridge_slave_serial_shifter.sv
// serial_shifter: LSB-first serial-in/parallel-out and parallel-load/serial-out register
module serial_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic         sin,
    input  logic [W-1:0] pin,
    output logic [W-1:0] pout,
    output logic         sout
);
    logic [W-1:0] data_q, data_d;
    always_comb data_d = load ? pin : shift_en ? {sin, data_q[W-1:1]} : data_q;
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end
    assign pout = data_q;
    assign sout = data_q[0];
endmodule

// File: rtl/bus_bridge_slave.sv
// bus_bridge_slave: serial bus slave that forwards requests to a remote bridge and returns read data
module bus_bridge_slave
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter bit SPLIT_EN     = 1'b1,
    parameter int SPLIT_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    input  logic                  master_ready,
    output logic                  rd_bus,
    output logic                  slave_ready,
    output logic                  slave_valid,
    output logic                  split,
    output logic                  bb_req_valid,
    input  logic                  bb_req_ready,
    output logic                  bb_req_we,
    output logic [ADDR_WIDTH-1:0] bb_req_addr,
    output logic [DATA_WIDTH-1:0] bb_req_wdata,
    input  logic                  bb_rsp_valid,
    input  logic [DATA_WIDTH-1:0] bb_rsp_rdata
);
    localparam int CW = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
    localparam int WW = $clog2(SPLIT_THRESH + 1);

    bb_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            split_q, split_d;
    logic            mode_q, mode_d;
    logic            addr_shift, data_shift, data_load, addr_last, data_last;
    logic [ADDR_WIDTH-1:0] addr_pout;
    logic [DATA_WIDTH-1:0] data_pout;
    logic            data_sout, unused_addr_sout;

    assign addr_shift = (state_q == IDLE || state_q == ADDR) && master_valid;
    assign data_shift = (state_q == WDATA && master_valid) || (state_q == RDATA && master_ready);
    assign data_load  = state_q == WAIT && bb_rsp_valid && mode_q == MODE_RD;
    assign addr_last  = cnt_q == CW'(ADDR_WIDTH - 1);
    assign data_last  = cnt_q == CW'(DATA_WIDTH - 1);

    serial_shifter #(.W(ADDR_WIDTH)) u_addr (
        .clk(clk), .rst(rst), .load(1'b0), .shift_en(addr_shift), .sin(wr_bus),
        .pin('0), .pout(addr_pout), .sout(unused_addr_sout)
    );

    // shared by write data (shift in) and read data (load, then shift out)
    serial_shifter #(.W(DATA_WIDTH)) u_data (
        .clk(clk), .rst(rst), .load(data_load), .shift_en(data_shift), .sin(wr_bus),
        .pin(bb_rsp_rdata), .pout(data_pout), .sout(data_sout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            split_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            split_q <= split_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (master_valid) state_d = ADDR;
            ADDR:    if (master_valid && addr_last) state_d = mode_q == MODE_WR ? WDATA : REQ;
            WDATA:   if (master_valid && data_last) state_d = REQ;
            REQ:     if (bb_req_ready) state_d = WAIT;
            WAIT:    if (bb_rsp_valid) state_d = mode_q == MODE_WR ? IDLE : RDATA;
            RDATA:   if (master_ready && data_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // the first address bit is taken in IDLE, so ADDR starts with one bit counted
    always_comb begin
        cnt_d   = state_q == IDLE ? CW'(master_valid)
                : state_d != state_q ? '0
                : (addr_shift || data_shift) ? cnt_q + 1'b1 : cnt_q;
        mode_d  = state_q == IDLE && master_valid ? mode : mode_q;
        wait_d  = state_q != WAIT ? '0 : wait_q == WW'(SPLIT_THRESH) ? wait_q : wait_q + 1'b1;
        split_d = SPLIT_EN && state_q == WAIT && !bb_rsp_valid
                  && (split_q || wait_q == WW'(SPLIT_THRESH - 1));
    end

    always_comb begin
        slave_ready  = state_q == IDLE;
        slave_valid  = state_q == RDATA;
        rd_bus       = state_q == RDATA && data_sout;
        split        = split_q;
        bb_req_valid = state_q == REQ;
        bb_req_we    = state_q == REQ && mode_q == MODE_WR;
        bb_req_addr  = state_q == REQ ? addr_pout : '0;
        bb_req_wdata = state_q == REQ && mode_q == MODE_WR ? data_pout : '0;
    end
endmodule

// File: tb/tb_bus_bridge_slave.sv
// tb_bus_bridge_slave: directed and randomized transactions checked against a transaction-level model
module tb_bus_bridge_slave;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TH = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          mode = 1'b0, wr_bus = 1'b0, master_valid = 1'b0, master_ready = 1'b0;
    logic          rd_bus, slave_ready, slave_valid, split;
    logic          bb_req_valid, bb_req_we;
    logic          bb_req_ready = 1'b0, bb_rsp_valid = 1'b0;
    logic [AW-1:0] bb_req_addr;
    logic [DW-1:0] bb_req_wdata;
    logic [DW-1:0] bb_rsp_rdata = '0;
    int            compared = 0, mismatched = 0;

    bus_bridge_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(1'b1), .SPLIT_THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
        .master_valid(master_valid), .master_ready(master_ready),
        .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid), .split(split),
        .bb_req_valid(bb_req_valid), .bb_req_ready(bb_req_ready), .bb_req_we(bb_req_we),
        .bb_req_addr(bb_req_addr), .bb_req_wdata(bb_req_wdata),
        .bb_rsp_valid(bb_rsp_valid), .bb_rsp_rdata(bb_rsp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One whole bus transaction; the model: split is high in WAIT cycle k (1-based) iff k > TH,
    // read data comes back LSB first, bits only advance on master_ready.
    task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] rdata, input int gaps, input int req_wait,
                       input int rsp_at, input int stall_bit, input int stall_len, input int abort_at);
        chk("idle_ready", slave_ready, 1);
        for (int i = 0; i < AW + (we ? DW : 0); i++) begin
            if (gaps == 2 || (gaps == 1 && $urandom_range(0, 1) == 1)) begin
                master_valid = 1'b0;
                wr_bus = 1'($urandom);
                mode = 1'($urandom);
                tick;
            end
            master_valid = 1'b1;
            if (i < AW) wr_bus = addr[i];
            else        wr_bus = wdata[i-AW];
            mode = i == 0 ? we : 1'($urandom);
            tick;
            if (i == 0) chk("busy_after_first_bit", slave_ready, 0);
        end
        master_valid = 1'b0;
        for (int d = 0; d <= req_wait; d++) begin
            bb_req_ready = d == req_wait;
            bb_rsp_valid = 1'($urandom);
            chk("req_valid", bb_req_valid, 1);
            chk("req_addr", bb_req_addr, addr);
            chk("req_we", bb_req_we, we);
            chk("req_wdata", bb_req_wdata, we ? wdata : 0);
            tick;
        end
        bb_req_ready = 1'b0;
        bb_rsp_valid = 1'b0;
        for (int k = 1; k <= rsp_at; k++) begin
            chk("wait_split", split, k > TH);
            chk("wait_req_valid", bb_req_valid, 0);
            chk("wait_slave_valid", slave_valid, 0);
            if (k == abort_at) begin
                master_valid = 1'b0;
                master_ready = 1'b0;
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk("rst_ready", slave_ready, 1);
                chk("rst_split", split, 0);
                chk("rst_req_valid", bb_req_valid, 0);
                bb_rsp_valid = 1'b1;
                bb_rsp_rdata = 8'($urandom);
                tick;
                bb_rsp_valid = 1'b0;
                chk("late_rsp_ready", slave_ready, 1);
                chk("late_rsp_valid", slave_valid, 0);
                return;
            end
            bb_rsp_valid = k == rsp_at;
            bb_rsp_rdata = k == rsp_at ? rdata : 8'($urandom);
            master_valid = 1'($urandom);
            master_ready = 1'($urandom);
            tick;
        end
        bb_rsp_valid = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        chk("rsp_split_clear", split, 0);
        if (we) begin
            chk("wr_done_ready", slave_ready, 1);
            chk("wr_no_valid", slave_valid, 0);
        end else begin
            for (int j = 0; j < DW; j++) begin
                for (int s = 0; s < (j == stall_bit ? stall_len : 0); s++) begin
                    master_ready = 1'b0;
                    master_valid = 1'($urandom);
                    chk("rd_hold_bit", rd_bus, rdata[j]);
                    chk("rd_hold_valid", slave_valid, 1);
                    tick;
                end
                master_valid = 1'b0;
                master_ready = 1'b1;
                chk("rd_bit", rd_bus, rdata[j]);
                chk("rd_valid", slave_valid, 1);
                tick;
            end
            master_ready = 1'b0;
            chk("rd_done_ready", slave_ready, 1);
            chk("rd_done_valid", slave_valid, 0);
            chk("rd_done_bus", rd_bus, 0);
        end
        bb_rsp_valid = 1'b1;
        master_ready = 1'b1;
        bb_req_ready = 1'b1;
        tick;
        bb_rsp_valid = 1'b0;
        master_ready = 1'b0;
        bb_req_ready = 1'b0;
        chk("idle_ignore_ready", slave_ready, 1);
        chk("idle_ignore_valid", slave_valid, 0);
        chk("idle_ignore_req", bb_req_valid, 0);
    endtask

    initial begin
        tick;
        tick;
        chk("reset_ready", slave_ready, 1);
        chk("reset_valid", slave_valid, 0);
        chk("reset_split", split, 0);
        chk("reset_req_valid", bb_req_valid, 0);
        chk("reset_req_we", bb_req_we, 0);
        chk("reset_req_addr", bb_req_addr, 0);
        chk("reset_req_wdata", bb_req_wdata, 0);
        chk("reset_rd_bus", rd_bus, 0);
        rst = 1'b0;
        txn(1'b0, 12'hA5C, 8'h00, 8'h3C, 0, 0, 1, 0, 0, 0);
        txn(1'b1, 12'h001, 8'hF0, 8'h00, 0, 0, 1, 0, 0, 0);
        txn(1'b0, 12'h5A3, 8'h00, 8'h96, 0, 0, 10, 0, 0, 0);
        txn(1'b0, 12'hA5C, 8'h00, 8'hC5, 2, 0, 1, 4, 3, 0);
        txn(1'b0, 12'h7E1, 8'h00, 8'h11, 0, 0, 10, 0, 0, 6);
        txn(1'b1, 12'h3B4, 8'h5D, 8'h00, 0, 5, TH, 0, 0, 0);
        txn(1'b0, 12'hFFF, 8'h00, 8'hFF, 1, 5, TH, 7, 2, 0);
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(1, 8);
            txn(1'($urandom), 12'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), r, $urandom_range(0, DW - 1), $urandom_range(0, 3),
                $urandom_range(0, 9) == 0 ? $urandom_range(1, r) : 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
